// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared ALU opcodes and muldiv sequencer state encoding
package muldiv_seq_pkg;
  localparam logic [7:0] ALU_ADD = 8'h01;
  localparam logic [7:0] ALU_SUB = 8'h02;
  localparam logic [7:0] ALU_MUL = 8'h03;
  localparam logic [7:0] ALU_DIV = 8'h04;
  localparam logic [7:0] ALU_MOD = 8'h05;
  localparam logic [7:0] ALU_AND = 8'h06;
  localparam logic [7:0] ALU_OR  = 8'h07;
  localparam logic [7:0] ALU_XOR = 8'h08;
  localparam logic [7:0] ALU_NOT = 8'h09;
  localparam logic [7:0] ALU_SHL = 8'h0A;
  localparam logic [7:0] ALU_SHR = 8'h0B;
  localparam logic [7:0] ALU_SAR = 8'h0C;
  localparam logic [7:0] ALU_ROL = 8'h0D;
  localparam logic [7:0] ALU_ROR = 8'h0E;
  localparam logic [7:0] ALU_CMP = 8'h0F;
  localparam logic [7:0] ALU_MOV = 8'h80;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MUL_RUN = 2'd1;
  localparam logic [1:0] ST_DIV_RUN = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;
  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_MUL_RUN = ST_MUL_RUN,
    S_DIV_RUN = ST_DIV_RUN,
    S_DONE    = ST_DONE
  } state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add or restoring-divide iteration on a shared WIDTH+1 adder
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] operand,
  input  logic             div_mode,
  output logic [WIDTH-1:0] acc_nxt,
  output logic             bit_nxt
);
  logic [WIDTH:0] a, b, sum;
  always_comb begin
    a = div_mode ? {acc, shift_in} : {1'b0, acc};
    b = (div_mode || shift_in) ? {1'b0, operand} : '0;
    // subtraction reuses the adder as a + ~b + 1
    sum = a + (b ^ {(WIDTH+1){div_mode}}) + {{WIDTH{1'b0}}, div_mode};
    acc_nxt = div_mode ? (sum[WIDTH] ? a[WIDTH-1:0] : sum[WIDTH-1:0]) : sum[WIDTH:1];
    bit_nxt = div_mode ? ~sum[WIDTH] : sum[0];
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned MUL/DIV/MOD sequencer, one iteration per clock
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero,
  output logic             illegal_op
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opr_q, opr_d, res_q, res_d, res_hi_q, res_hi_d;
  logic mod_q, mod_d, dz_q, dz_d, il_q, il_d;
  logic [WIDTH-1:0] acc_nxt;
  logic bit_nxt, div_mode, accept;
  assign div_mode = state_q == S_DIV_RUN;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc(hi_q),
    .shift_in(div_mode ? lo_q[WIDTH-1] : lo_q[0]),
    .operand(opr_q),
    .div_mode(div_mode),
    .acc_nxt(acc_nxt),
    .bit_nxt(bit_nxt)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    opr_d = opr_q;
    mod_d = mod_q;
    res_d = res_q;
    res_hi_d = res_hi_q;
    dz_d = dz_q;
    il_d = il_q;
    accept = start && (state_q == S_IDLE || state_q == S_DONE);
    if (accept) begin
      cnt_d = '0;
      dz_d = 1'b0;
      il_d = 1'b0;
      res_d = '0;
      res_hi_d = '0;
      hi_d = '0;
      mod_d = alu_op == ALU_MOD;
      if (alu_op == ALU_MUL) begin
        state_d = S_MUL_RUN;
        lo_d = op_b;
        opr_d = op_a;
      end else if (alu_op == ALU_DIV || alu_op == ALU_MOD) begin
        if (op_b == '0) begin
          state_d = S_DONE;
          dz_d = 1'b1;
          res_d = mod_d ? op_a : '1;
          res_hi_d = mod_d ? '1 : op_a;
        end else begin
          state_d = S_DIV_RUN;
          lo_d = op_a;
          opr_d = op_b;
        end
      end else begin
        state_d = S_DONE;
        il_d = 1'b1;
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end else if (state_q != S_IDLE) begin
      cnt_d = cnt_q + 1'b1;
      hi_d = acc_nxt;
      lo_d = div_mode ? {lo_q[WIDTH-2:0], bit_nxt} : {bit_nxt, lo_q[WIDTH-1:1]};
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        state_d = S_DONE;
        res_d = mod_q ? hi_d : lo_d;
        res_hi_d = mod_q ? lo_d : hi_d;
      end
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      opr_q <= '0;
      mod_q <= 1'b0;
      res_q <= '0;
      res_hi_q <= '0;
      dz_q <= 1'b0;
      il_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      opr_q <= opr_d;
      mod_q <= mod_d;
      res_q <= res_d;
      res_hi_q <= res_hi_d;
      dz_q <= dz_d;
      il_q <= il_d;
    end
  end
  assign busy = state_q == S_MUL_RUN || state_q == S_DIV_RUN;
  assign done = state_q == S_DONE;
  assign result = res_q;
  assign result_hi = res_hi_q;
  assign div_zero = dz_q;
  assign illegal_op = il_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table, random and hand-sequenced checks of muldiv_seq
module tb_muldiv_seq;
  localparam int W = 16;
  typedef struct {
    logic [7:0]   op;
    logic [W-1:0] a, b, r, h;
    logic         dz, il;
    int           lat;
  } vec_t;
  logic clock = 1'b0, reset = 1'b0, start = 1'b0;
  logic [7:0] alu_op = '0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic busy, done, div_zero, illegal_op;
  logic [W-1:0] result, result_hi;
  int checks = 0, failures = 0;
  vec_t vecs[11];

  muldiv_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .alu_op(alu_op),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
    .result_hi(result_hi), .div_zero(div_zero), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic vec_t model(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    logic [2*W-1:0] p;
    v.op = op; v.a = a; v.b = b; v.dz = 0; v.il = 0; v.lat = W + 1;
    if (op == 8'h03) begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      v.r = p[W-1:0]; v.h = p[2*W-1:W];
    end else if (op == 8'h04 || op == 8'h05) begin
      if (b == 0) begin
        v.dz = 1; v.lat = 1;
        v.r = (op == 8'h04) ? {W{1'b1}} : a;
        v.h = (op == 8'h04) ? a : {W{1'b1}};
      end else begin
        v.r = (op == 8'h04) ? a / b : a % b;
        v.h = (op == 8'h04) ? a % b : a / b;
      end
    end else begin
      v.il = 1; v.lat = 1; v.r = 0; v.h = 0;
    end
    return v;
  endfunction

  task automatic launch(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    alu_op = op; op_a = a; op_b = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); alu_op = 8'($urandom);
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    lat = -1; busy_ok = 1;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin lat = n; return; end
      if (!busy) busy_ok = 0;
      @(posedge clock); #1;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    bit bok;
    launch(v.op, v.a, v.b);
    wait_done(lat, bok);
    chk({tag, "_lat"}, lat, v.lat);
    chk({tag, "_busy"}, 32'(bok), 32'd1);
    chk({tag, "_res"}, {v.h, v.r} == {result_hi, result} ? 32'd1 : {result_hi, result}, v.h == result_hi && v.r == result ? 32'd1 : {v.h, v.r});
    chk({tag, "_flags"}, {div_zero, illegal_op}, {v.dz, v.il});
  endtask

  initial begin
    int lat, seen;
    bit bok;
    vec_t v;
    vecs[0]  = '{8'h03, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 0, 0, 17};
    vecs[1]  = '{8'h03, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0, 17};
    vecs[2]  = '{8'h04, 16'd100, 16'd7, 16'd14, 16'd2, 0, 0, 17};
    vecs[3]  = '{8'h05, 16'd100, 16'd7, 16'd2, 16'd14, 0, 0, 17};
    vecs[4]  = '{8'h04, 16'd5, 16'd9, 16'd0, 16'd5, 0, 0, 17};
    vecs[5]  = '{8'h04, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1, 0, 1};
    vecs[6]  = '{8'h01, 16'h1234, 16'h0005, 16'h0000, 16'h0000, 0, 1, 1};
    vecs[7]  = '{8'h05, 16'h0007, 16'h0000, 16'h0007, 16'hFFFF, 1, 0, 1};
    vecs[8]  = '{8'h04, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 0, 0, 17};
    vecs[9]  = '{8'h03, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 0, 0, 17};
    vecs[10] = '{8'h05, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 0, 0, 17};
    #12;
    chk("rst_outs", {busy, done, div_zero, illegal_op, result, result_hi}, '0);
    reset = 1'b1;
    for (int i = 0; i < 11; i++) begin
      chk("table_model", {model(vecs[i].op, vecs[i].a, vecs[i].b).r, model(vecs[i].op, vecs[i].a, vecs[i].b).h}, {vecs[i].r, vecs[i].h});
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end
    for (int i = 0; i < 40; i++) begin
      logic [7:0] op;
      logic [W-1:0] a, b;
      op = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(3, 5));
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom >> $urandom_range(0, 15));
      run_vec($sformatf("rnd%0d", i), model(op, a, b));
    end
    launch(8'h03, 16'd3, 16'd4);
    repeat (4) @(posedge clock);
    #1; alu_op = 8'h04; op_a = 16'd9; op_b = 16'd3; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    wait_done(lat, bok);
    chk("repulse_lat", lat, 12);
    chk("repulse_res", {result_hi, result}, 32'd12);
    alu_op = 8'h04; op_a = 16'd9; op_b = 16'd3; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    chk("b2b_busy", {busy, done, result}, {1'b1, 1'b0, 16'd0});
    wait_done(lat, bok);
    chk("b2b_lat", lat, 17);
    chk("b2b_res", {result_hi, result}, {16'd0, 16'd3});
    launch(8'h03, 16'h1234, 16'h5678);
    repeat (8) @(posedge clock);
    #1; reset = 1'b0;
    #1;
    chk("abort_outs", {busy, done, result, result_hi, div_zero, illegal_op}, '0);
    @(negedge clock); reset = 1'b1;
    seen = 0;
    repeat (20) begin @(posedge clock); #1; if (done || busy) seen++; end
    chk("abort_quiet", seen, 0);
    run_vec("post_abort", model(8'h03, 16'd2, 16'd2));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
